// File: rtl/attn_stream_pkg.sv
// Shared types and helpers for the attention stream adapter.
package attn_stream_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DRAIN   = 3'd5
   } state_t;

   // Bit offset of element i inside a flattened frame bus.
   function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned dw);
      return i * dw;
   endfunction

endpackage

// File: rtl/attention_stream_adapter.sv
// Streams a frame in, packs it onto the core's x_in bus, runs the core once,
// captures out_final and streams it back out one element per beat.
module attention_stream_adapter
   import attn_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int L          = 8,
   parameter int N          = 1,
   parameter int E          = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_last,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [DATA_WIDTH-1:0]          m_data,
   output logic                           m_last,
   output logic                           core_start,
   input  logic                           core_done,
   output logic [DATA_WIDTH*L*N*E-1:0]    core_x,
   input  logic [DATA_WIDTH*L*N*E-1:0]    core_y,
   output logic                           busy,
   output logic                           frame_err
);

   localparam int TOTAL = L * N * E;
   localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int XW    = DATA_WIDTH * TOTAL;
   localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   in_cnt_q, in_cnt_d;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [XW-1:0]   x_buf_q, x_buf_d;
   logic [XW-1:0]   y_buf_q, y_buf_d;

   // Next-state, counter and handshake logic for the load/run/drain sequence.
   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      x_buf_d    = x_buf_q;
      y_buf_d    = y_buf_q;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      core_start = 1'b0;
      frame_err  = 1'b0;
      unique case (state_q)
         S_IDLE, S_LOAD: begin
            // Gated by rst_n so the adapter never advertises ready while held in reset.
            s_ready = rst_n;
            if (s_valid && rst_n) begin
               x_buf_d[elem_lsb(int'(in_cnt_q), DATA_WIDTH) +: DATA_WIDTH] = s_data;
               if (in_cnt_q == LAST_IDX) begin
                  frame_err = ~s_last;
                  in_cnt_d  = '0;
                  state_d   = S_START;
               end else if (s_last) begin
                  // Short frame: drop it and wait for a fresh one.
                  frame_err = 1'b1;
                  in_cnt_d  = '0;
                  state_d   = S_IDLE;
               end else begin
                  in_cnt_d  = in_cnt_q + CW'(1);
                  state_d   = S_LOAD;
               end
            end
         end
         S_START: begin
            core_start = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // The core registers out_final in its done cycle, so sample one cycle later.
            y_buf_d   = core_y;
            out_cnt_d = '0;
            state_d   = S_DRAIN;
         end
         S_DRAIN: begin
            m_valid = 1'b1;
            m_last  = (out_cnt_q == LAST_IDX);
            if (m_ready) begin
               if (out_cnt_q == LAST_IDX) begin
                  out_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  out_cnt_d = out_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign m_data = y_buf_q[elem_lsb(int'(out_cnt_q), DATA_WIDTH) +: DATA_WIDTH];
   assign core_x = x_buf_q;
   assign busy   = (state_q != S_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Input and output element counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
      end
   end

   // Frame buffers: packed input toward the core and captured core result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_buf_q <= '0;
         y_buf_q <= '0;
      end else begin
         x_buf_q <= x_buf_d;
         y_buf_q <= y_buf_d;
      end
   end

endmodule

// File: tb/tb_attention_stream_adapter.sv
// Directed bench for attention_stream_adapter with a 4-element frame.
module tb_attention_stream_adapter;

   localparam int DW    = 16;
   localparam int L     = 2;
   localparam int N     = 1;
   localparam int E     = 2;
   localparam int TOTAL = L * N * E;
   localparam int XW    = DW * TOTAL;
   localparam logic [XW-1:0] Y_FRAME = 64'h000D_000C_000B_000A;

   typedef struct {
      logic [DW-1:0] exp_out;
      logic          exp_mlast;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          core_start;
   logic          core_done = 1'b0;
   logic [XW-1:0] core_x;
   logic [XW-1:0] core_y = '0;
   logic          busy;
   logic          frame_err;

   int errors = 0;
   int checks = 0;
   int start_pulses = 0;
   int err_pulses = 0;
   logic [DW:0] log_q[$];
   vec_t tbl[TOTAL];

   attention_stream_adapter #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_start(core_start), .core_done(core_done),
      .core_x(core_x), .core_y(core_y),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Event monitors: start pulses, framing errors and accepted output beats.
   always @(posedge clk) begin
      if (rst_n && core_start) start_pulses++;
      if (frame_err) err_pulses++;
      if (m_valid && m_ready) log_q.push_back({m_last, m_data});
   end

   task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [DW-1:0] base, input int nbeats, input int last_pos, input bit gaps);
      for (int i = 0; i < nbeats; i++) begin
         int w;
         int g;
         w = 0;
         g = gaps ? $urandom_range(0, 2) : 0;
         s_valid = 1'b0;
         if (g > 0) tick(g);
         s_valid = 1'b1;
         s_data  = base + DW'(i);
         s_last  = (i == last_pos);
         while (!s_ready && w < 20) begin
            tick(1);
            w++;
         end
         if (w >= 20) check("s_ready_timeout", 64'(s_ready), 64'd1);
         tick(1);
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic drain(input int stall_at, input int stall_len);
      for (int i = 0; i < TOTAL; i++) begin
         int w;
         w = 0;
         while (!m_valid && w < 20) begin
            tick(1);
            w++;
         end
         check("m_valid_wait", 64'(m_valid), 64'd1);
         if (i == stall_at) begin
            m_ready = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               tick(1);
               check("stall_hold_data", 64'(m_data), 64'(tbl[i].exp_out));
               check("stall_hold_valid", 64'(m_valid), 64'd1);
            end
         end
         check("m_data", 64'(m_data), 64'(tbl[i].exp_out));
         check("m_last", 64'(m_last), 64'(tbl[i].exp_mlast));
         m_ready = 1'b1;
         tick(1);
         m_ready = 1'b0;
      end
   endtask

   // Called right after the final input beat has been accepted.
   task automatic core_cycle(input logic [XW-1:0] exp_x, input int stall_at);
      check("core_start_after_last", 64'(core_start), 64'd1);
      check("core_x", core_x, exp_x);
      tick(1);
      check("core_start_single", 64'(core_start), 64'd0);
      check("s_ready_in_wait", 64'(s_ready), 64'd0);
      check("busy_in_wait", 64'(busy), 64'd1);
      tick(4);
      core_y    = Y_FRAME;
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      check("m_valid_in_capture", 64'(m_valid), 64'd0);
      tick(1);
      check("m_valid_two_after_done", 64'(m_valid), 64'd1);
      drain(stall_at, 3);
      check("busy_after_drain", 64'(busy), 64'd0);
   endtask

   task automatic check_log;
      check("beat_count", 64'(log_q.size()), 64'(TOTAL));
      for (int i = 0; i < TOTAL && i < log_q.size(); i++)
         check("beat_seq", 64'(log_q[i]), 64'({tbl[i].exp_mlast, tbl[i].exp_out}));
   endtask

   initial begin
      int sp;
      int ep;
      tbl[0] = '{16'h000A, 1'b0};
      tbl[1] = '{16'h000B, 1'b0};
      tbl[2] = '{16'h000C, 1'b0};
      tbl[3] = '{16'h000D, 1'b1};

      // Reset values
      tick(2);
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_core_start", 64'(core_start), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_m_data", 64'(m_data), 64'd0);
      check("rst_core_x", core_x, 64'd0);
      rst_n = 1'b1;
      tick(1);
      check("s_ready_after_release", 64'(s_ready), 64'd1);

      // Clean frame
      log_q.delete();
      send_frame(16'h0001, 4, 3, 1'b0);
      core_cycle(64'h0004_0003_0002_0001, -1);
      check_log();
      check("start_pulses_f1", 64'(start_pulses), 64'd1);
      check("no_err_f1", 64'(err_pulses), 64'd0);

      // Input gaps and a downstream stall on the second output beat
      log_q.delete();
      send_frame(16'h0101, 4, 3, 1'b1);
      core_cycle(64'h0104_0103_0102_0101, 1);
      check_log();

      // Early s_last on the second beat, then a clean frame
      sp = start_pulses;
      ep = err_pulses;
      send_frame(16'h0031, 2, 1, 1'b0);
      check("early_last_err", 64'(err_pulses), 64'(ep + 1));
      check("early_last_idle", 64'(busy), 64'd0);
      tick(3);
      check("early_last_no_start", 64'(start_pulses), 64'(sp));
      log_q.delete();
      send_frame(16'h0041, 4, 3, 1'b0);
      core_cycle(64'h0044_0043_0042_0041, -1);
      check_log();
      check("clean_after_early_err", 64'(err_pulses), 64'(ep + 1));

      // Missing s_last on the final beat
      ep = err_pulses;
      send_frame(16'h0051, 4, -1, 1'b0);
      check("missing_last_err", 64'(err_pulses), 64'(ep + 1));
      core_cycle(64'h0054_0053_0052_0051, -1);

      // Reset while waiting on the core
      sp = start_pulses;
      send_frame(16'h0061, 4, 3, 1'b0);
      tick(2);
      check("wait_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_s_ready", 64'(s_ready), 64'd0);
      check("midrst_m_valid", 64'(m_valid), 64'd0);
      check("midrst_core_start", 64'(core_start), 64'd0);
      check("midrst_core_x", core_x, 64'd0);
      check("midrst_m_data", 64'(m_data), 64'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      log_q.delete();
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      tick(5);
      check("post_rst_no_beats", 64'(log_q.size()), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_m_valid", 64'(m_valid), 64'd0);
      check("post_rst_s_ready", 64'(s_ready), 64'd1);

      // core_done while idle is ignored
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      check("idle_done_busy", 64'(busy), 64'd0);
      tick(3);
      check("idle_done_busy_later", 64'(busy), 64'd0);
      check("idle_done_m_valid", 64'(m_valid), 64'd0);
      check("idle_done_no_beats", 64'(log_q.size()), 64'd0);
      check("idle_done_no_start", 64'(start_pulses), 64'(sp + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/attention_stream_adapter.md
# attention_stream_adapter

Streaming front/back end for the single-head attention+MLP core. It accepts one token element per beat over a valid/ready input stream and packs a full (L, N, E) frame into the core's flattened `x_in` bus. It then pulses the core's `start`, waits for `done`, and captures `out_final`. Finally it replays the result as a valid/ready output stream, so the core's wide parallel ports become narrow streams for the rest of the SoC.

## Interface
Parameters:
- DATA_WIDTH, 16, element width in bits
- L, 8, sequence length
- N, 1, batch size
- E, 8, embedding dimension

Derived: TOTAL = L*N*E beats per frame.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  adapter can accept an input beat
- s_data  in  DATA_WIDTH  input element
- s_last  in  1  marks the final beat of an input frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the output beat
- m_data  out  DATA_WIDTH  output element
- m_last  out  1  marks the final beat of an output frame
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core done pulse
- core_x  out  DATA_WIDTH*TOTAL  packed frame driven to the core's `x_in`
- core_y  in  DATA_WIDTH*TOTAL  the core's `out_final`
- busy  out  1  high in any state other than S_IDLE
- frame_err  out  1  one-cycle pulse on a framing error

## Operation
- Element index i = (l*N + n)*E + e occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. Streams carry i = 0 first and TOTAL-1 last.
- States are S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE and S_DRAIN. S_IDLE is the reset state.
- S_IDLE / S_LOAD:
  - s_ready = 1. An accepted beat (s_valid && s_ready) writes element in_cnt of core_x, then in_cnt increments.
  - A beat accepted in S_IDLE moves the FSM to S_LOAD.
  - Accepting beat TOTAL-1 moves the FSM to S_START and clears in_cnt.
- Early s_last (s_last on an accepted beat with index < TOTAL-1): frame_err pulses, in_cnt clears, the FSM returns to S_IDLE and the partial frame is discarded. Written elements are left stale; they are overwritten by the next frame.
- Missing s_last on beat TOTAL-1: frame_err pulses and the frame proceeds normally.
- S_START: core_start = 1 for exactly one cycle, then S_WAIT.
- S_WAIT: s_ready = 0. core_done moves the FSM to S_CAPTURE. core_done in any other state is ignored.
- S_CAPTURE: y_buf <= core_y, out_cnt clears, then S_DRAIN.
- S_DRAIN:
  - m_valid = 1, m_data = element out_cnt of y_buf, m_last = (out_cnt == TOTAL-1).
  - On m_valid && m_ready, out_cnt increments.
  - The handshake on the last beat returns the FSM to S_IDLE.
- The adapter processes one frame at a time; input is not accepted in S_START, S_WAIT, S_CAPTURE or S_DRAIN.
- Counter widths are $clog2(TOTAL) bits, minimum 1. Counters never wrap inside a frame.

## Timing
- Reset values: s_ready = 0 (it is driven from state, so it reads 1 in S_IDLE the first cycle after reset release). m_valid, m_last, core_start, busy and frame_err are 0. m_data, core_x and y_buf are all zeros. in_cnt and out_cnt are 0.
- Reset asserted mid-operation returns everything to reset values immediately, with no pending core_start or m_valid.
- core_x is stable from the cycle after the last input beat until the next frame's first beat is accepted.
- core_start is asserted the cycle after the last input beat is accepted.
- core_y is sampled in S_CAPTURE, one cycle after core_done. This is required because the core registers `out_final` in its done cycle.
- The first m_valid is asserted 2 cycles after core_done.
- m_data and m_last stay stable while m_valid && !m_ready.
- Best-case throughput: 1 beat/cycle on each stream.
- Frame overhead: TOTAL + 1 + core latency + 2 + TOTAL cycles.

## Structure
- Package attn_stream_pkg holds:
  - the state_t enum (3-bit);
  - the function elem_lsb(i) = i*DATA_WIDTH, used for packing and unpacking.
- No sub-module is needed. The FSM, both counters and both buffers live in the single module.
- Use separate always_ff blocks for state, counters and buffers, and an always_comb block for next-state and handshake logic.

## Test plan
All scenarios use L=2, N=1, E=2 (TOTAL=4).
- Input 0x0001..0x0004 with s_last on beat 4, then core_done 5 cycles after core_start, with core_y = {0x0D,0x0C,0x0B,0x0A} (element 3 in the MSBs) -> core_x = {0x0004,0x0003,0x0002,0x0001}, exactly one core_start pulse, and output beats 0x0A, 0x0B, 0x0C, 0x0D with m_last on 0x0D.
- Random s_valid gaps and m_ready held low 3 cycles mid-drain -> no lost or duplicated beats, and m_data holds at 0x0B during the stall.
- s_last on beat 2 -> frame_err pulses, no core_start, and the next clean 4-beat frame completes normally.
- Beat 4 sent without s_last -> frame_err pulses and core_start still fires.
- rst_n pulsed low in S_WAIT -> all outputs return to reset values, and a later core_done causes no output beats.
- core_done pulsed in S_IDLE -> ignored: busy stays 0 and m_valid stays 0.
